pipe_stall_ctrl: RTL and testbench

Central pipeline stall controller for the 5-stage CPU. It merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data SRAM wait) into the per-stage stall bus consumed by PC/IF/ID/EX/MEM/WB. It sequences the divider's occupancy with a down-counter FSM and generates the one-cycle capture strobe that ID uses to buffer its instruction on the first frozen cycle. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stall_ctrl
//  Description : Central stall controller for the 5-stage pipeline. Merges
//                the ID load-use, EX divide and MEM SRAM-wait stall requests
//                into the per-stage stall bus, sequences divider occupancy
//                with a down-counter FSM, strobes ID capture on the first
//                frozen cycle and keeps a saturating stall-cycle counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          : pipeline clock
//    resetn       : asynchronous active-low reset
//    stallreq_id  : load-use hazard from ID (level)
//    stallreq_mem : data SRAM not ready (level)
//    div_start    : EX holds a div/divu (level, held while EX is frozen)
//    stall        : per-stage stall bus, bit0=PC .. bit5=WB, 1 = stop
//    div_busy     : divider FSM in BUSY
//    div_done     : divider FSM in DONE (result valid for EX)
//    id_capture   : first cycle of an ID freeze
//    stall_cnt    : saturating count of cycles with stall[0]=1
// ============================================================================
module pipe_stall_ctrl #(
    parameter int STALL_W    = 6,
    parameter int DIV_CYCLES = 33,
    parameter int CNT_W      = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               div_start,
    output logic [STALL_W-1:0] stall,
    output logic               div_busy,
    output logic               div_done,
    output logic               id_capture,
    output logic [31:0]        stall_cnt
);

    // Stall patterns: each is a contiguous low-order run of ones, so the
    // first un-stalled stage after the frozen ones receives a bubble.
    localparam logic [STALL_W-1:0] c_STALL_MEM = STALL_W'(5'b11111);
    localparam logic [STALL_W-1:0] c_STALL_EX  = STALL_W'(4'b1111);
    localparam logic [STALL_W-1:0] c_STALL_ID  = STALL_W'(3'b111);
    localparam logic [CNT_W-1:0]   c_CNT_LOAD  = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               stall2_q;
    logic [31:0]        stall_cnt_q;
    logic [31:0]        stall_cnt_d;
    logic               w_div_ex_stop;

    // The issue cycle itself already freezes EX, before the FSM has left
    // IDLE; that is why the raw div_start term appears here. Gating with
    // resetn keeps every stall output low while reset is held, even though
    // the request inputs are purely combinational paths.
    always_comb begin
        w_div_ex_stop = resetn &&
                        (((state_q == S_IDLE) && div_start) || (state_q == S_BUSY));
    end

    always_comb begin
        stall = '0;
        if (resetn) begin
            if (stallreq_mem) begin
                stall = c_STALL_MEM;
            end else if (w_div_ex_stop) begin
                stall = c_STALL_EX;
            end else if (stallreq_id) begin
                stall = c_STALL_ID;
            end
        end
    end

    // Divider occupancy FSM. The counter runs regardless of other stalls;
    // only the DONE -> IDLE exit waits for EX to actually advance.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (div_start) begin
                        cnt_q   <= c_CNT_LOAD;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q - c_CNT_ONE;
                    if (cnt_q == c_CNT_ONE) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!stall[3]) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign div_busy = (state_q == S_BUSY);
    assign div_done = (state_q == S_DONE);

    // Edge detect on the ID freeze. Because it looks only at stall[2], a
    // hand-over between stall sources without a gap stays one freeze.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall2_q <= 1'b0;
        end else begin
            stall2_q <= stall[2];
        end
    end

    assign id_capture = stall[2] & ~stall2_q;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stall_ctrl
//  Description : Self-checking bench for pipe_stall_ctrl. A cycle-level
//                reference model (divide tracked as "frozen cycles left" plus
//                a done flag) is compared against the DUT on every falling
//                edge; directed sequences add hand-computed literal checks,
//                then a randomized phase exercises mixed requests and resets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stall_ctrl;

    localparam int STALL_W    = 6;
    localparam int DIV_CYCLES = 33;
    localparam int CNT_W      = 6;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               stallreq_id = 1'b0;
    logic               stallreq_mem = 1'b0;
    logic               div_start = 1'b0;
    logic [STALL_W-1:0] stall;
    logic               div_busy;
    logic               div_done;
    logic               id_capture;
    logic [31:0]        stall_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stall_ctrl #(
        .STALL_W   (STALL_W),
        .DIV_CYCLES(DIV_CYCLES),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .stallreq_id (stallreq_id),
        .stallreq_mem(stallreq_mem),
        .div_start   (div_start),
        .stall       (stall),
        .div_busy    (div_busy),
        .div_done    (div_done),
        .id_capture  (id_capture),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_left = 0;      // EX-frozen BUSY cycles still to come
    bit          m_done = 1'b0;
    bit          m_prev2 = 1'b0;
    logic [63:0] m_cnt = 64'd0;
    int          preset_seq = 0;
    int          seen_seq = 0;

    function automatic logic [5:0] exp_stall();
        bit idle;
        idle = (m_left == 0) && !m_done;
        if (!resetn)                          return 6'h00;
        if (stallreq_mem)                     return 6'h1F;
        if ((idle && div_start) || m_left > 0) return 6'h0F;
        if (stallreq_id)                      return 6'h07;
        return 6'h00;
    endfunction

    always @(posedge clk or negedge resetn) begin
        logic [5:0]  s;
        logic [63:0] base;
        if (!resetn) begin
            m_left  <= 0;
            m_done  <= 1'b0;
            m_prev2 <= 1'b0;
            m_cnt   <= 64'd0;
            seen_seq <= preset_seq;
        end else begin
            s = exp_stall();
            if ((m_left == 0) && !m_done && div_start) begin
                m_left <= DIV_CYCLES - 1;
            end else if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_done <= 1'b1;
            end else if (m_done && !s[3]) begin
                m_done <= 1'b0;
            end
            m_prev2 <= s[2];
            base = (preset_seq != seen_seq) ? 64'hFFFF_FFFE : m_cnt;
            seen_seq <= preset_seq;
            m_cnt <= (s[0] && base < 64'hFFFF_FFFF) ? base + 64'd1 : base;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        logic [5:0] s;
        if (chk_en) begin
            s = exp_stall();
            check("stall",      {58'd0, stall},      {58'd0, s});
            check("div_busy",   {63'd0, div_busy},   {63'd0, resetn && (m_left > 0)});
            check("div_done",   {63'd0, div_done},   {63'd0, resetn && m_done});
            check("id_capture", {63'd0, id_capture}, {63'd0, s[2] && !m_prev2});
            check("stall_cnt",  {32'd0, stall_cnt},  m_cnt);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus helpers ----------------
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_mem = 1'b0;
        div_start    = 1'b0;
        next();
        next();
        resetn = 1'b1;
    endtask

    initial begin
        next();
        chk_en = 1'b1;

        // 1: reset state, then asynchronous reset overriding a request
        do_reset();
        @(negedge clk);
        check("t1 stall", {58'd0, stall}, 64'h0);
        check("t1 busy",  {63'd0, div_busy}, 64'h0);
        check("t1 done",  {63'd0, div_done}, 64'h0);
        check("t1 cnt",   {32'd0, stall_cnt}, 64'h0);
        next();
        stallreq_mem = 1'b1;
        #1 resetn = 1'b0;
        #1 check("t1 async stall", {58'd0, stall}, 64'h0);
        #1 resetn = 1'b1;
        stallreq_mem = 1'b0;

        // 2: single-cycle load-use stall
        do_reset();
        stallreq_id = 1'b1;
        @(negedge clk);
        check("t2 stall", {58'd0, stall}, 64'h07);
        check("t2 cap",   {63'd0, id_capture}, 64'h1);
        next();
        stallreq_id = 1'b0;
        @(negedge clk);
        check("t2 cnt", {32'd0, stall_cnt}, 64'd1);

        // 3: plain divide
        do_reset();
        for (int t = 0; t <= 35; t++) begin
            div_start = (t < 34);
            @(negedge clk);
            if (t == 0)  check("t3 stall0",  {58'd0, stall}, 64'h0F);
            if (t == 1)  check("t3 busy1",   {63'd0, div_busy}, 64'h1);
            if (t == 32) check("t3 stall32", {58'd0, stall}, 64'h0F);
            if (t == 32) check("t3 done32",  {63'd0, div_done}, 64'h0);
            if (t == 33) check("t3 done33",  {63'd0, div_done}, 64'h1);
            if (t == 33) check("t3 stall33", {58'd0, stall}, 64'h00);
            if (t == 34) check("t3 idle34",  {62'd0, div_busy, div_done}, 64'h0);
            if (t == 35) check("t3 cnt",     {32'd0, stall_cnt}, 64'd33);
            next();
        end

        // 4: divide with MEM stalls overlapping BUSY and DONE
        do_reset();
        for (int t = 0; t <= 38; t++) begin
            div_start    = (t < 37);
            stallreq_mem = (t == 10) || (t >= 33 && t <= 35);
            @(negedge clk);
            if (t == 10) check("t4 stall10", {58'd0, stall}, 64'h1F);
            if (t == 32) check("t4 busy32",  {63'd0, div_busy}, 64'h1);
            if (t == 33) check("t4 stall33", {58'd0, stall}, 64'h1F);
            if (t == 33) check("t4 done33",  {63'd0, div_done}, 64'h1);
            if (t == 36) check("t4 done36",  {63'd0, div_done}, 64'h1);
            if (t == 36) check("t4 stall36", {58'd0, stall}, 64'h00);
            if (t == 37) check("t4 idle37",  {62'd0, div_busy, div_done}, 64'h0);
            if (t == 38) check("t4 no reissue", {58'd0, stall}, 64'h00);
            next();
        end
        stallreq_mem = 1'b0;

        // 5: back-to-back ID freezes from different sources
        do_reset();
        for (int t = 0; t <= 2; t++) begin
            stallreq_id  = 1'b1;
            stallreq_mem = (t == 1);
            @(negedge clk);
            check("t5 stall", {58'd0, stall}, (t == 1) ? 64'h1F : 64'h07);
            check("t5 cap",   {63'd0, id_capture}, (t == 0) ? 64'h1 : 64'h0);
            next();
        end
        stallreq_id  = 1'b0;
        stallreq_mem = 1'b0;

        // 6: counter saturation
        do_reset();
        @(negedge clk);
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        preset_seq++;
        #1 release dut.stall_cnt_q;
        next();
        stallreq_id = 1'b1;
        next();
        next();
        next();
        stallreq_id = 1'b0;
        @(negedge clk);
        check("t6 saturate", {32'd0, stall_cnt}, 64'hFFFF_FFFF);
        next();

        // randomized phase
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            stallreq_mem = ($urandom_range(0, 99) < 15);
            stallreq_id  = ($urandom_range(0, 99) < 20);
            div_start    = ($urandom_range(0, 99) < 12);
            if ($urandom_range(0, 499) == 0) begin
                #1 resetn = 1'b0;
                next();
                #2 resetn = 1'b1;
            end else begin
                next();
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
